// File: rtl/float_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_types_pkg
// Description : Shared single-precision constants and pipeline register
//               types for the FPU datapath.
// Revision    : 1.1 - added EXP_MAX, MANT_W and the norm_s1_t stage record
// ============================================================================
package float_types_pkg;

  // All-ones biased exponent: infinity / NaN encoding.
  localparam logic [7:0] EXP_MAX = 8'hFF;

  // Significand width including the hidden bit.
  localparam int MANT_W = 24;

  // Width of a leading-zero count over MANT_W bits (0..24).
  localparam int LZ_W = 5;

  // Stage-1 register of the normalise/round stage.
  typedef struct packed {
    logic [MANT_W:0]   mag;    // magnitude of the raw sum, carry in the MSB
    logic              carry;  // addition carried into bit MANT_W
    logic [LZ_W-1:0]   lz;     // leading zeros of mag[MANT_W-1:0]
    logic              sign;
    logic [7:0]        exp;    // common aligned exponent
  } norm_s1_t;

endpackage
`default_nettype wire

// File: rtl/lzc24.sv
`default_nettype none
// ============================================================================
// Module      : lzc24
// Description : Combinational leading-zero counter, 24-bit input, returns 24
//               for an all-zero input.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  count_o
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) begin
        count_o = 5'(23 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/norm_round_stage.sv
`default_nettype none
// ============================================================================
// Module      : norm_round_stage
// Description : Two-stage normalise / round-to-nearest-even / pack stage that
//               follows the FPU adder sum stage, with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_round_stage #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [MANT_W:0]   mant_i,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic              eff_sub_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  import float_types_pkg::*;

  // The datapath never adds or subtracts the bias; the exponent is carried
  // through in its biased form, so a non-standard BIAS changes nothing here.
  if (BIAS != (1 << (EXP_W - 1)) - 1) begin : g_bias_nonstandard
  end

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic     s1_valid_q, s1_valid_d;
  logic     valid_o_q, valid_o_d;
  logic     s1_advance;
  logic     in_fire;

  assign s1_advance = s1_valid_q && (!valid_o_q || ready_i);
  assign ready_o    = !s1_valid_q || s1_advance;
  assign in_fire    = valid_i && ready_o;
  assign s1_valid_d = in_fire || (s1_valid_q && !s1_advance);
  assign valid_o_d  = s1_advance || (valid_o_q && !ready_i);

  // ---------------------------------------------------------------------------
  // Stage 1: magnitude recovery and leading-zero count
  // ---------------------------------------------------------------------------
  logic [MANT_W:0] mag_s1;
  logic [4:0]      lz_s1;
  norm_s1_t        s1_d, s1_q;

  // A subtraction that went negative wraps; negate to get the magnitude.
  assign mag_s1 = (eff_sub_i && mant_i[MANT_W]) ? (-mant_i) : mant_i;

  lzc24 u_lzc (
    .data_i  (mag_s1[MANT_W-1:0]),
    .count_o (lz_s1)
  );

  assign s1_d = '{mag:   mag_s1,
                  carry: !eff_sub_i && mag_s1[MANT_W],
                  lz:    lz_s1,
                  sign:  sign_i,
                  exp:   exp_i};

  // Stage-1 register: valid bit plus payload captured on acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift, exponent adjust, RNE, pack and flag
  // ---------------------------------------------------------------------------
  logic signed [9:0] exp10, lz10, e;
  logic [24:0]       m_rnd;
  logic [23:0]       m;
  logic              normal;
  logic [31:0]       result_d;
  logic              zero_d, overflow_d, underflow_d;
  logic              unused_hidden;

  assign exp10 = signed'({2'b00, s1_q.exp});
  assign lz10  = signed'({5'b00000, s1_q.lz});

  // The hidden bit is implicit in the packed format and is dropped on output.
  assign unused_hidden = m[23] ^ m_rnd[23];

  // Classify the stage-1 value and build the packed result and flags.
  always_comb begin
    result_d    = '0;
    zero_d      = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    e           = '0;
    m           = '0;
    m_rnd       = '0;
    normal      = 1'b0;

    if (s1_q.mag == '0) begin
      // Exact cancellation always yields +0.
      zero_d = 1'b1;
    end else if (s1_q.carry) begin
      // Drop one bit; with no sticky bit a set guard is an exact tie.
      m_rnd  = {1'b0, s1_q.mag[24:1]} + 25'(s1_q.mag[0] & s1_q.mag[1]);
      e      = exp10 + 10'sd1;
      normal = 1'b1;
      if (m_rnd[24]) begin
        m = 24'h800000;
        e = e + 10'sd1;
      end else begin
        m = m_rnd[23:0];
      end
    end else if (s1_q.lz == '0) begin
      m      = s1_q.mag[23:0];
      e      = exp10;
      normal = 1'b1;
    end else if (exp10 > lz10) begin
      // Left normalisation is exact: only zeros shift in.
      m      = s1_q.mag[23:0] << s1_q.lz;
      e      = exp10 - lz10;
      normal = 1'b1;
    end else begin
      // Would need a denormal; flush to signed zero instead.
      underflow_d = 1'b1;
      result_d    = {s1_q.sign, 31'b0};
    end

    if (normal) begin
      if (e >= 10'sd255) begin
        overflow_d = 1'b1;
        result_d   = {s1_q.sign, EXP_MAX, 23'b0};
      end else begin
        result_d   = {s1_q.sign, e[7:0], m[22:0]};
      end
    end
  end

  // Output register: loads when stage 1 advances, holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o_q   <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      valid_o_q <= valid_o_d;
      if (s1_advance) begin
        result_o    <= result_d;
        zero_o      <= zero_d;
        overflow_o  <= overflow_d;
        underflow_o <= underflow_d;
      end
    end
  end

  assign valid_o = valid_o_q;

endmodule
`default_nettype wire

// File: tb/tb_norm_round_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_round_stage
// Description : Self-checking bench for norm_round_stage: directed vectors,
//               backpressure, mid-stream reset and randomized traffic against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_round_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [24:0] mant_i = '0;
  logic        sign_i = 1'b0;
  logic [7:0]  exp_i = 8'd1;
  logic        eff_sub_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o, overflow_o, underflow_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [34:0] exp_out;  // {result, zero, overflow, underflow}
    int          stamp;
  } item_t;
  item_t q[$];

  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;
  logic        saw_not_ready = 1'b0;

  norm_round_stage #(.EXP_W(8), .MANT_W(24), .BIAS(127)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mant_i      (mant_i),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .eff_sub_i   (eff_sub_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: value-level normalise / RNE / pack using plain integers.
  function automatic logic [34:0] model(input logic [24:0] mant, input logic sgn,
                                        input logic [7:0] ex, input logic eff);
    int mag, t, m, e, lz;
    if (eff && mant[24]) mag = 33554432 - int'(mant);
    else                 mag = int'(mant);
    if (mag == 0) return {32'h0, 3'b100};
    if (!eff && mag >= 16777216) begin
      m = mag / 2;
      e = int'(ex) + 1;
      if ((mag % 2 == 1) && (m % 2 == 1)) m = m + 1;
      if (m == 16777216) begin
        m = 8388608;
        e = e + 1;
      end
    end else begin
      t = mag % 16777216;
      lz = 0;
      while (lz < 24 && t < (1 << (23 - lz))) lz++;
      if (lz == 0) begin
        m = t;
        e = int'(ex);
      end else if (int'(ex) > lz) begin
        m = (t << lz) % 16777216;
        e = int'(ex) - lz;
      end else begin
        return {sgn, 31'b0, 3'b001};
      end
    end
    if (e >= 255) return {sgn, 8'hFF, 23'b0, 3'b010};
    return {sgn, 8'(e), 23'(m % 8388608), 3'b000};
  endfunction

  // Per-cycle compare against the in-flight queue of expected results.
  always @(negedge clk) begin
    if (rst_i) begin
      q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("valid_o", valid_o, (q.size() > 0) && (cyc >= q[0].stamp + 2));
      chk("ready_o", ready_o, !(q.size() == 2 && !ready_i));
      if (!ready_o) saw_not_ready <= 1'b1;
      if (valid_o && prev_stall)
        chk("hold_stable", {result_o, zero_o, overflow_o, underflow_o}, prev_out);
      if (valid_o && q.size() > 0) begin
        chk("out_beat", {result_o, zero_o, overflow_o, underflow_o}, q[0].exp_out);
        if (ready_i) void'(q.pop_front());
      end
      prev_stall <= valid_o && !ready_i;
      prev_out   <= {result_o, zero_o, overflow_o, underflow_o};
      if (valid_i && ready_o)
        q.push_back('{exp_out: model(mant_i, sign_i, exp_i, eff_sub_i), stamp: cyc});
    end
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [24:0] mt, input logic sg, input logic [7:0] ex, input logic ef);
    bit ok = 1'b0;
    mant_i = mt; sign_i = sg; exp_i = ex; eff_sub_i = ef; valid_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  typedef struct {
    logic [24:0] mant;
    logic        sign;
    logic [7:0]  ex;
    logic        eff;
    logic [34:0] want;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // 1.FFFFFF x 2^1 rounds up to exactly 2^2 -> biased exponent 129.
    vecs = '{
      '{25'h1000000, 1'b0, 8'd127, 1'b0, {32'h40000000, 3'b000}},
      '{25'h0200000, 1'b0, 8'd127, 1'b1, {32'h3E800000, 3'b000}},
      '{25'h1E00000, 1'b1, 8'd127, 1'b1, {32'hBE800000, 3'b000}},
      '{25'h0000000, 1'b1, 8'd127, 1'b1, {32'h00000000, 3'b100}},
      '{25'h0000001, 1'b0, 8'd5,   1'b0, {32'h00000000, 3'b001}},
      '{25'h0000001, 1'b1, 8'd5,   1'b1, {32'h80000000, 3'b001}},
      '{25'h1000003, 1'b0, 8'd127, 1'b0, {32'h40000002, 3'b000}},
      '{25'h1000001, 1'b0, 8'd127, 1'b0, {32'h40000000, 3'b000}},
      '{25'h1FFFFFF, 1'b0, 8'd127, 1'b0, {32'h40800000, 3'b000}},
      '{25'h1FFFFFE, 1'b0, 8'd254, 1'b0, {32'h7F800000, 3'b010}},
      '{25'h1FFFFFF, 1'b1, 8'd253, 1'b0, {32'hFF800000, 3'b010}},
      '{25'h0800000, 1'b0, 8'd127, 1'b0, {32'h3F800000, 3'b000}},
      '{25'h0000001, 1'b0, 8'd24,  1'b0, {32'h00800000, 3'b000}},
      '{25'h0000001, 1'b0, 8'd23,  1'b0, {32'h00000000, 3'b001}}
    };

    // Reset and reset-state checks.
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_result", result_o, 32'h0);
    chk("reset_flags", {zero_o, overflow_o, underflow_o}, 3'b000);
    chk("reset_valid_o", valid_o, 1'b0);
    chk("reset_ready_o", ready_o, 1'b1);

    // Pin the reference model to hand-derived values.
    foreach (vecs[i])
      chk($sformatf("model_vec%0d", i), model(vecs[i].mant, vecs[i].sign, vecs[i].ex, vecs[i].eff), vecs[i].want);

    // Directed vectors back to back through the DUT.
    @(posedge clk); #1;
    foreach (vecs[i]) send(vecs[i].mant, vecs[i].sign, vecs[i].ex, vecs[i].eff);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four beats while downstream stalls three cycles.
    saw_not_ready = 1'b0;
    fork
      begin
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
      begin
        send(25'h1000000, 1'b0, 8'd100, 1'b0);
        send(25'h0400000, 1'b1, 8'd90,  1'b1);
        send(25'h1000003, 1'b0, 8'd60,  1'b0);
        send(25'h0000000, 1'b0, 8'd60,  1'b1);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ready_dropped", saw_not_ready, 1'b1);
    chk("bp_drained", q.size(), 0);

    // Reset mid-stream discards in-flight beats.
    send(25'h1234567, 1'b0, 8'd130, 1'b0);
    send(25'h0ABCDEF, 1'b1, 8'd140, 1'b1);
    mant_i = 25'h0F0F0F0; valid_i = 1'b1; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("midreset_valid_o", valid_o, 1'b0);
    chk("midreset_ready_o", ready_o, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with random downstream stalls.
    for (int n = 0; n < 3000; n++) begin
      valid_i   = ($urandom_range(0, 9) < 7);
      ready_i   = ($urandom_range(0, 9) < 7);
      eff_sub_i = 1'(($urandom_range(0, 1)));
      sign_i    = 1'(($urandom_range(0, 1)));
      case ($urandom_range(0, 3))
        0:       mant_i = 25'($urandom);
        1:       mant_i = 25'($urandom) >> $urandom_range(0, 24);
        2:       mant_i = 25'h1FFFFFF - 25'($urandom_range(0, 3));
        default: mant_i = 25'h1000000 | 25'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 3))
        0:       exp_i = 8'($urandom_range(1, 30));
        1:       exp_i = 8'($urandom_range(245, 254));
        default: exp_i = 8'($urandom_range(1, 254));
      endcase
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #1;
    chk("final_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
